pdm_modulator: RTL

PDM_MODULATOR -- requirements
Module: pdm_modulator

---
 rtl/pdm_modulator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pdm_modulator.sv
// PCM-to-PDM converter: small PCM sample FIFO feeding a 2nd-order sigma-delta loop.
// Optional build macro PDM_MODULATOR_DITHER_EN adds LFSR dither ahead of the first integrator.
module pdm_modulator #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     stb_pdm,
  input  logic                     stb_pcm,
  input  logic [15:0]              pcm_in,
  input  logic                     pcm_valid,
  output logic                     pcm_ready,
  output logic                     pdm_out,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = ACC_W + 2;

  localparam logic signed [SW-1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = -MAXV;
  localparam logic signed [SW-1:0] FB_P = SW'(32768);
  localparam logic signed [SW-1:0] FB_N = -FB_P;

  // ---------------- PCM FIFO ----------------
  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign pcm_ready = (level_q != LW'(DEPTH));
  assign push      = pcm_valid & pcm_ready;
  assign pop       = stb_pcm & (level_q != '0);
  assign level     = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pcm_in;
  end

  // ---------------- sigma-delta loop ----------------
  logic [15:0]              x_q;
  logic signed [ACC_W-1:0]  i1_q, i2_q, i1_d, i2_d;
  logic                     pdm_q, pdm_d;
  logic                     und_q;
  logic signed [SW-1:0]     xe, fb, dith, s1, s2, i1_x, i2_x, i1n_x;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    c = v;
    if (v > MAXV)      c = MAXV;
    else if (v < MINV) c = MINV;
    return c[ACC_W-1:0];
  endfunction

`ifdef PDM_MODULATOR_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (en && stb_pdm) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // lfsr[3:0]-8 gives a zero-centred -8..+7 offset
  assign dith = $signed({{(SW-4){1'b0}}, lfsr_q[3:0]}) - SW'(8);
`else
  assign dith = '0;
`endif

  always_comb begin
    xe    = $signed({{(SW-16){x_q[15]}}, x_q}) + dith;
    fb    = pdm_q ? FB_P : FB_N;
    i1_x  = $signed({{2{i1_q[ACC_W-1]}}, i1_q});
    i2_x  = $signed({{2{i2_q[ACC_W-1]}}, i2_q});
    s1    = i1_x + xe - fb;
    i1_d  = sat(s1);
    i1n_x = $signed({{2{i1_d[ACC_W-1]}}, i1_d});
    s2    = i2_x + i1n_x - fb;
    i2_d  = sat(s2);
    pdm_d = ~i2_d[ACC_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      x_q      <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      pdm_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        x_q      <= mem_q[rd_ptr_q];
      end
      // a new underrun beats a clear in the same cycle
      if (stb_pcm && (level_q == '0)) und_q <= 1'b1;
      else if (underrun_clr)          und_q <= 1'b0;
      if (!en) begin
        i1_q <= '0;
        i2_q <= '0;
        if (stb_pdm) pdm_q <= ~pdm_q;
      end else if (stb_pdm) begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        pdm_q <= pdm_d;
      end
    end
  end

  assign pdm_out  = pdm_q;
  assign underrun = und_q;

endmodule
